// File: rtl/odd_parity_rx_checker.sv
// Serial frame receiver: start, DATA_W payload bits LSB first, odd parity, stop.
// Reports payload, parity/framing errors and a saturating parity-error count.
module odd_parity_rx_checker #(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 bit_en,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        errcnt_d = errcnt_q;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    // Any low sample starts a frame; no mid-bit recheck.
                    if (!serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = serial_in;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    data_d  = shift_q;
                    // Odd parity: payload XOR parity bit must be 1.
                    perr_d  = ~(^shift_q ^ par_q);
                    ferr_d  = ~serial_in;
                    dv_d    = 1'b1;
                    if (perr_d && (errcnt_q != {ERR_CNT_W{1'b1}}))
                        errcnt_d = errcnt_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
    assign err_count  = errcnt_q;

endmodule

// File: tb/tb_odd_parity_rx_checker.sv
// Bench for odd_parity_rx_checker: directed frame table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_odd_parity_rx_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       bit_en;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    odd_parity_rx_checker #(.DATA_W(4), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] data;
        logic       p;
        logic       stop;
        logic [3:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic [7:0] exp_cnt;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   dv_seen = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    int   mcnt = 0;
    logic [3:0] last_d = '0;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;
    logic [7:0] last_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit period: (per-1) cycles without strobe, then one strobe cycle.
    task automatic send_bit(input logic b, input int per);
        serial_in = b;
        bit_en    = 1'b0;
        repeat (per - 1) tick();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] data, input logic p, input logic stop, input int per);
        exp_t e;
        send_bit(1'b0, per);
        for (int i = 0; i < 4; i++) send_bit(data[i], per);
        send_bit(p, per);
        e.d  = data;
        e.pe = ($countones({data, p}) % 2) == 0;
        e.fe = !stop;
        if (e.pe && mcnt < 255) mcnt++;
        e.cnt = 8'(mcnt);
        exp_q.push_back(e);
        send_bit(stop, per);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mcnt     = 0;
        last_d   = '0;
        last_pe  = 1'b0;
        last_fe  = 1'b0;
        last_cnt = '0;
    endtask

    // Scoreboard: each pulse must match the next expected frame; outputs hold otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_valid === 1'b1) begin
                exp_t e;
                dv_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_valid", 32'(data_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data_out", 32'(data_out), 32'(e.d));
                    chk("mon_parity_err", 32'(parity_err), 32'(e.pe));
                    chk("mon_frame_err", 32'(frame_err), 32'(e.fe));
                    chk("mon_err_count", 32'(err_count), 32'(e.cnt));
                    last_d   = e.d;
                    last_pe  = e.pe;
                    last_fe  = e.fe;
                    last_cnt = e.cnt;
                end
            end else begin
                chk("hold_outputs", {8'(data_out), 7'd0, parity_err, 7'd0, frame_err, err_count},
                    {8'(last_d), 7'd0, last_pe, 7'd0, last_fe, last_cnt});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   dv0;
        logic [3:0] rd;

        vt[0] = '{4'b1010, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 8'd0};
        vt[1] = '{4'b1111, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 8'd1};
        vt[2] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd1};
        vt[3] = '{4'b0101, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 8'd1};
        vt[4] = '{4'b0011, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 8'd2};
        vt[5] = '{4'b0111, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 8'd2};

        rst = 1'b1; serial_in = 1'b1; bit_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        chk("reset_outputs", {8'(data_out), 3'd0, data_valid, parity_err, frame_err, busy, 1'b0, err_count},
            32'd0);

        // Directed table, bit_en every cycle so frames run back to back.
        foreach (vt[i]) begin
            send_frame(vt[i].data, vt[i].p, vt[i].stop, 1);
            chk($sformatf("tbl%0d_data_valid", i), 32'(data_valid), 32'd1);
            chk($sformatf("tbl%0d_data_out", i), 32'(data_out), 32'(vt[i].exp_data));
            chk($sformatf("tbl%0d_parity_err", i), 32'(parity_err), 32'(vt[i].exp_perr));
            chk($sformatf("tbl%0d_frame_err", i), 32'(frame_err), 32'(vt[i].exp_ferr));
            chk($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(vt[i].exp_cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
        end
        tick();
        chk("dv_one_cycle", 32'(data_valid), 32'd0);

        // Strobe every 3 cycles with idle gaps, then two back-to-back frames.
        dv0 = dv_seen;
        repeat ($urandom_range(1, 4)) send_bit(1'b1, 3);
        send_frame(4'($urandom), 1'($urandom), 1'b1, 3);
        send_frame(4'($urandom), 1'($urandom), 1'b1, 3);
        repeat (4) tick();
        chk("b2b_pulse_count", 32'(dv_seen - dv0), 32'd2);

        // Randomized frames, periods and gaps.
        for (int n = 0; n < 30; n++) begin
            int per;
            per = $urandom_range(1, 4);
            repeat ($urandom_range(0, 3)) send_bit(1'b1, per);
            send_frame(4'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), per);
        end
        repeat (3) tick();
        chk("random_all_consumed", 32'(exp_q.size()), 32'd0);

        // Reset after d1, with a simultaneous strobe carrying a 0.
        send_bit(1'b0, 1);
        chk("busy_after_start", 32'(busy), 32'd1);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        dv0 = dv_seen;
        serial_in = 1'b0; bit_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; bit_en = 1'b0; serial_in = 1'b1;
        model_reset();
        chk("midrst_outputs", {8'(data_out), 3'd0, data_valid, parity_err, frame_err, busy, 1'b0, err_count},
            32'd0);
        repeat (8) tick();
        chk("midrst_no_pulse", 32'(dv_seen - dv0), 32'd0);
        send_frame(4'b1001, 1'b1, 1'b1, 2);
        chk("postrst_data_out", 32'(data_out), 32'h9);
        chk("postrst_flags", {30'd0, parity_err, frame_err}, 32'd0);

        // 256 parity-bad frames saturate the counter; one more must hold it.
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        for (int n = 0; n < 256; n++) begin
            rd = 4'($urandom);
            send_frame(rd, ^rd, 1'b1, 1);
        end
        chk("sat_255", 32'(err_count), 32'd255);
        rd = 4'($urandom);
        send_frame(rd, ^rd, 1'b1, 1);
        chk("sat_hold", 32'(err_count), 32'd255);
        chk("sat_perr", 32'(parity_err), 32'd1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/odd_parity_rx_checker.md
ODD_PARITY_RX_CHECKER -- requirements
Module: odd_parity_rx_checker

Interface
REQ-001 Parameter: DATA_W, 4, payload bits per frame (the only supported value is 4).
REQ-002 Parameter: ERR_CNT_W, 8, width of the parity-error counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 serial_in  input  1  serial line; idles at 1.
REQ-006 bit_en  input  1  one-cycle strobe, once per bit period; serial_in is sampled only in cycles where bit_en=1.
REQ-007 data_out  output  DATA_W  payload of the last completed frame.
REQ-008 data_valid  output  1  one-cycle pulse when data_out, parity_err and frame_err update.
REQ-009 parity_err  output  1  last frame failed the odd-parity check.
REQ-010 frame_err  output  1  last frame had stop bit = 0.
REQ-011 busy  output  1  high while the FSM is not in IDLE.
REQ-012 err_count  output  ERR_CNT_W  saturating count of frames with parity_err=1.

Function
REQ-013 Frame format, one bit per bit_en sample:
- start bit = 0;
- d0..d3, LSB first;
- parity bit p;
- stop bit = 1.
REQ-014 Odd parity: a frame is parity-correct when (d3^d2^d1^d0^p) = 1.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 Transitions: every transition happens only on a cycle with bit_en=1; with bit_en=0 the state, bit counter and shift register hold.
REQ-017 IDLE: serial_in=0 -> DATA with bit counter=0; serial_in=1 -> stay in IDLE.
REQ-018 DATA: shift the sample into bit position [counter], increment the counter; after the 4th sample go to PARITY.
REQ-019 PARITY: capture p and go to STOP.
REQ-020 STOP: capture the stop bit and go to IDLE.
REQ-021 On the clock edge that completes the STOP sample:
- data_out, parity_err and frame_err load together;
- data_valid=1 for exactly that following cycle.
REQ-022 data_out loads even when the frame has an error; both error flags may be 1 at the same time.
REQ-023 data_out, parity_err and frame_err hold between data_valid pulses.
REQ-024 err_count increments by 1 on each data_valid with parity_err=1 and saturates at 2^ERR_CNT_W-1 (no wrap).
REQ-025 busy=0 in IDLE and 1 in DATA, PARITY and STOP.
REQ-026 Start-bit validity is not rechecked; a 0 sampled in IDLE always starts a frame.
REQ-027 Latency: data_valid is asserted in the clock cycle immediately after the clock edge on which the stop bit is sampled.
REQ-028 Back-to-back frames: a start bit on the bit_en sample immediately after the stop bit is accepted with no gap.

Reset
REQ-029 When rst=1 at a clock edge, all of the following take effect:
- state <- IDLE; bit counter <- 0; shift register <- 0;
- data_out <- 0; data_valid <- 0;
- parity_err <- 0; frame_err <- 0; busy <- 0;
- err_count <- 0.
REQ-030 rst has priority over bit_en.
REQ-031 Reset mid-frame discards the partial frame: no data_valid, no flag update, no counter update.
REQ-032 After reset is released, the next frame is received correctly starting from its start bit.

Verification
REQ-033 Bits 0,0,1,0,1,1,1 (start, d0..d3, p, stop) -> data_valid pulse; data_out=1010, parity_err=0, frame_err=0, err_count=0.
REQ-034 Data 1111 with p=0 -> data_out=1111, parity_err=1, err_count=1; data 0000 with p=1 sent next -> parity_err=0, err_count stays 1.
REQ-035 Data 0101, p=1, stop=0 -> data_out=0101, frame_err=1, parity_err=0; data_valid still pulses for one cycle.
REQ-036 bit_en pulsed every 3 cycles with random idle gaps, followed by two back-to-back frames -> both frames decoded, exactly two data_valid pulses.
REQ-037 rst=1 after d1 of a frame -> busy=0 and all outputs 0 on the next cycle, no data_valid; a following full frame decodes correctly.
REQ-038 256 consecutive parity-bad frames -> err_count=255 and held at 255.
